// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf_pkg
// Purpose : Shared GF(2^8) definitions for the Reed-Solomon decoder datapath:
//           field width, reduction polynomial, the pipeline record type and a
//           combinational field multiplier.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gf_pkg;

  localparam int         GF_W     = 8;
  localparam logic [8:0] GF_POLY  = 9'h11D;  // x^8 + x^4 + x^3 + x^2 + 1
  // Widest requester ID any instance needs (N_REQ <= 8).
  localparam int         ID_MAX_W = 3;

  // One pipeline stage / response record. Narrower instances zero-extend id.
  typedef struct packed {
    logic                v;
    logic [ID_MAX_W-1:0] id;
    logic [GF_W-1:0]     x;
    logic                zero;
  } rsp_t;

  // Shift-and-add multiply, reducing by GF_POLY after every doubling.
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b);
    logic [GF_W-1:0] p;
    logic [GF_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[GF_W-1] ? ((aa << 1) ^ GF_POLY[GF_W-1:0]) : (aa << 1);
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf256_inv.sv
`default_nettype none
// ============================================================================
// Module  : gf256_inv
// Purpose : Combinational GF(256) inverse, y = x^254 (0 maps to 0).
// Ports   : i_x  [8] operand
//           o_inv[8] multiplicative inverse of i_x
// Revision: 1.0 - initial release
// ============================================================================
module gf256_inv
  import gf_pkg::*;
(
  input  logic [GF_W-1:0] i_x,
  output logic [GF_W-1:0] o_inv
);

  logic [GF_W-1:0] w_sq;
  logic [GF_W-1:0] w_acc;

  // x^254 = x^2 * x^4 * ... * x^128: square repeatedly, accumulate each power.
  always_comb begin
    w_sq  = i_x;
    w_acc = 8'h01;
    for (int i = 1; i < GF_W; i++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_acc = gf_mul(w_acc, w_sq);
    end
    o_inv = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/gf256_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : gf256_rr_pick
// Purpose : Round-robin pick. Grants the first valid requester found scanning
//           upward from i_ptr, modulo N_REQ.
// Ports   : i_valid  [N_REQ] request vector
//           i_ptr    [ID_W]  highest-priority index
//           o_gnt    [N_REQ] one-hot grant (all zero when nothing valid)
//           o_gnt_idx[ID_W]  binary index of the grant
//           o_any    [1]     some requester granted
// Revision: 1.0 - initial release
// ============================================================================
module gf256_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_idx,
  output logic             o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // One extra bit so ptr+i never overflows before the modulo wrap.
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!o_any && i_valid[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gf256_inv_sched.sv
`default_nettype none
// ============================================================================
// Module  : gf256_inv_sched
// Purpose : Shares one GF(256) inverter among N_REQ requesters. Round-robin
//           accept of one operand per clock, fixed LAT-cycle pipeline, single
//           ID-tagged response bus without backpressure.
// Ports   : i_clk               clock, rising edge
//           i_rst               asynchronous active-high reset
//           i_req_valid[N_REQ]  per-requester operand valid
//           i_req_data[8*N_REQ] operands, requester k at [8k+7:8k]
//           o_req_ready[N_REQ]  one-hot grant (combinational)
//           i_flush             drop all in-flight operations at the edge
//           o_rsp_valid         response valid
//           o_rsp_id[ID_W]      requester index of the response
//           o_rsp_data[8]       inverse of the operand (0 for operand 0)
//           o_rsp_zero          operand was 0
//           o_inflight[3]       accepted operations not yet responded
// Revision: 1.0 - initial release
// ============================================================================
module gf256_inv_sched
  import gf_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic                 i_flush,
  output logic                 o_rsp_valid,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [GF_W-1:0]      o_rsp_data,
  output logic                 o_rsp_zero,
  output logic [2:0]           o_inflight
);

  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  rsp_t             stg_q [LAT];
  rsp_t             stg_d [LAT];

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_accept;
  logic [GF_W-1:0]  w_sel_x;
  logic [GF_W-1:0]  w_inv;
  logic [2:0]       w_cnt;
  logic             w_unused_id;

  gf256_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_valid   (i_req_valid),
    .i_ptr     (ptr_q),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // The single shared inverter, fed from stage 1.
  gf256_inv u_inv (
    .i_x   (stg_q[0].x),
    .o_inv (w_inv)
  );

  // Flush and reset both mask the grant so nothing is accepted on those edges.
  assign o_req_ready = (i_flush || i_rst) ? '0 : w_gnt;
  assign w_accept    = w_any && !i_flush && !i_rst;

  always_comb begin
    w_sel_x = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) w_sel_x = i_req_data[8*k +: 8];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_accept) begin
      ptr_d = (w_gnt_idx == ID_W'(N_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);
    end
  end

  // Payload fields load only alongside a valid so outputs hold when idle.
  always_comb begin
    for (int k = 0; k < LAT; k++) stg_d[k] = stg_q[k];
    stg_d[0].v = w_accept;
    if (w_accept) begin
      stg_d[0].id   = ID_MAX_W'(w_gnt_idx);
      stg_d[0].x    = w_sel_x;
      stg_d[0].zero = (w_sel_x == '0);
    end
    for (int k = 1; k < LAT; k++) begin
      stg_d[k].v = stg_q[k-1].v && !i_flush;
      if (stg_q[k-1].v && !i_flush) begin
        stg_d[k].id   = stg_q[k-1].id;
        stg_d[k].x    = (k == 1) ? w_inv : stg_q[k-1].x;
        stg_d[k].zero = stg_q[k-1].zero;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
      for (int k = 0; k < LAT; k++) stg_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < LAT; k++) stg_q[k] <= stg_d[k];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < LAT; k++) w_cnt = w_cnt + 3'(stg_q[k].v);
  end

  assign o_inflight  = w_cnt;
  assign o_rsp_valid = stg_q[LAT-1].v;
  assign o_rsp_id    = stg_q[LAT-1].id[ID_W-1:0];
  assign o_rsp_zero  = stg_q[LAT-1].zero;
  // Upper id bits are always zero when ID_W < ID_MAX_W.
  assign w_unused_id = ^stg_q[LAT-1].id;

  generate
    if (LAT == 1) begin : g_lat1
      assign o_rsp_data = w_inv;
    end else begin : g_latn
      assign o_rsp_data = stg_q[LAT-1].x;
    end
  endgenerate

endmodule
`default_nettype wire
